// File: rtl/sha1_pkg.sv
// Shared SHA-1 padding definitions: sequencer states, block geometry,
// pad byte and the post-pad state selection helper.
package sha1_pkg;

  localparam int SHA1_BLOCK_WORDS = 16;

  typedef logic [$clog2(SHA1_BLOCK_WORDS)-1:0] idx_t;

  localparam idx_t SHA1_LEN_WORD_HI = idx_t'(14);
  localparam idx_t SHA1_LAST_WORD   = idx_t'(SHA1_BLOCK_WORDS - 1);
  localparam logic [7:0] SHA1_PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_MSG,
    ST_ONE,
    ST_ZERO,
    ST_LEN_HI,
    ST_LEN_LO
  } state_t;

  // After the 0x80 word: land on the length pair, or zero-fill toward it
  function automatic state_t tail_state(input idx_t nx);
    return (nx == SHA1_LEN_WORD_HI) ? ST_LEN_HI : ST_ZERO;
  endfunction

endpackage

// File: rtl/sha1_pad_sequencer_if.sv
// Bus bundle of the SHA-1 pad sequencer: control, memory port and
// padded-word stream. master = sequencer side, slave = environment side.
interface sha1_pad_sequencer_if;

  logic        start;
  logic [15:0] message_addr;
  logic [31:0] message_size;

  logic [15:0] port_A_addr;
  logic        read_en;
  logic [31:0] port_A_rddata;

  logic        w_valid;
  logic [31:0] w_data;
  logic        w_ready;
  logic        block_last;
  logic        msg_last;
  logic        busy;

  modport master (
    input  start,
    input  message_addr,
    input  message_size,
    input  port_A_rddata,
    input  w_ready,
    output port_A_addr,
    output read_en,
    output w_valid,
    output w_data,
    output block_last,
    output msg_last,
    output busy
  );

  modport slave (
    output start,
    output message_addr,
    output message_size,
    output port_A_rddata,
    output w_ready,
    input  port_A_addr,
    input  read_en,
    input  w_valid,
    input  w_data,
    input  block_last,
    input  msg_last,
    input  busy
  );

endinterface

// File: rtl/sha1_word_pad.sv
// Final-word padder: keeps the upper r message bytes, inserts 0x80, clears
// the rest. SHA1_BYTE_SWAP_EN byte-reverses little-endian memory data first.
module sha1_word_pad
  import sha1_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  r,
  output logic [31:0] word
);

  logic [31:0] be;

`ifdef SHA1_BYTE_SWAP_EN
  assign be = {data[7:0], data[15:8], data[23:16], data[31:24]};
`else
  assign be = data;
`endif

  // r == 0 means a full message word passes through untouched
  always_comb begin
    word = be;
    unique case (r)
      2'd1:    word = {be[31:24], SHA1_PAD_BYTE, 16'h0000};
      2'd2:    word = {be[31:16], SHA1_PAD_BYTE, 8'h00};
      2'd3:    word = {be[31:8], SHA1_PAD_BYTE};
      default: word = be;
    endcase
  end

endmodule

// File: rtl/sha1_pad_sequencer.sv
// SHA-1 pad sequencer: streams message words, 0x80, zero fill and the
// 64-bit bit length as 16-word blocks. Build option: SHA1_BYTE_SWAP_EN.
module sha1_pad_sequencer
  import sha1_pkg::*;
(
  input logic clk,
  input logic reset,
  sha1_pad_sequencer_if.master bus
);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] size_q, size_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] data_q, data_d;
  idx_t        idx_q, idx_d;

  idx_t        idx_nx;
  logic [1:0]  r;
  logic [31:0] pad_w;
  logic        valid;
  logic        rd_en;
  logic        mlast;
  logic [31:0] wdata;

  assign r = (rem_q < 32'd4) ? rem_q[1:0] : 2'd0;

  sha1_word_pad u_pad (
    .data (data_q),
    .r    (r),
    .word (pad_w)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    rem_d   = rem_q;
    data_d  = data_q;
    idx_d   = idx_q;
    idx_nx  = idx_q + idx_t'(1);
    valid   = 1'b0;
    rd_en   = 1'b0;
    mlast   = 1'b0;
    wdata   = 32'h0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          size_d  = bus.message_size;
          rem_d   = bus.message_size;
          addr_d  = bus.message_addr;
          idx_d   = '0;
          state_d = (bus.message_size == 32'd0) ? ST_ONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        addr_d  = addr_q + 16'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        data_d  = bus.port_A_rddata;
        state_d = ST_MSG;
      end
      ST_MSG: begin
        valid = 1'b1;
        wdata = pad_w;
        if (bus.w_ready) begin
          idx_d = idx_nx;
          if (rem_q > 32'd4) begin
            rem_d   = rem_q - 32'd4;
            state_d = ST_FETCH;
          end else if (rem_q == 32'd4) begin
            rem_d   = 32'd0;
            state_d = ST_ONE;
          end else begin
            // partial word already carried the 0x80 byte
            rem_d   = 32'd0;
            state_d = tail_state(idx_nx);
          end
        end
      end
      ST_ONE: begin
        valid = 1'b1;
        wdata = {SHA1_PAD_BYTE, 24'h0};
        if (bus.w_ready) begin
          idx_d   = idx_nx;
          state_d = tail_state(idx_nx);
        end
      end
      ST_ZERO: begin
        valid = 1'b1;
        if (bus.w_ready) begin
          idx_d = idx_nx;
          if (idx_nx == SHA1_LEN_WORD_HI) begin
            state_d = ST_LEN_HI;
          end
        end
      end
      ST_LEN_HI: begin
        valid = 1'b1;
        wdata = {29'd0, size_q[31:29]};
        if (bus.w_ready) begin
          idx_d   = idx_nx;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        valid = 1'b1;
        mlast = 1'b1;
        wdata = {size_q[28:0], 3'b000};
        if (bus.w_ready) begin
          idx_d   = idx_nx;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.port_A_addr = addr_q;
  assign bus.read_en     = rd_en;
  assign bus.w_valid     = valid;
  assign bus.w_data      = wdata;
  assign bus.msg_last    = mlast;
  assign bus.block_last  = valid && (idx_q == SHA1_LAST_WORD);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha1_pad_sequencer.sv
// Scoreboard bench for sha1_pad_sequencer: a byte-level SHA-1 padding
// model fills an expectation queue; a monitor checks each accepted word.
module tb_sha1_pad_sequencer;

  typedef struct packed {
    logic [31:0] d;
    logic        bl;
    logic        ml;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  sha1_pad_sequencer_if bus ();

  sha1_pad_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  exp_t        exp_q [$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          words_seen  = 0;
  int          reads_seen  = 0;
  int          stall_cnt   = 0;
  bit          ready_mode  = 1'b0;
  logic        rd_pend     = 1'b0;
  logic [15:0] pend_addr   = 16'h0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit length
  task automatic build_expect(input logic [15:0] a, input logic [31:0] sz);
    logic [7:0]  b [$];
    logic [31:0] w;
    logic [63:0] bits;
    int          n;
    exp_t        e;
    for (int i = 0; i < int'(sz); i++) begin
      w = mem[a + 16'(i / 4)];
`ifdef SHA1_BYTE_SWAP_EN
      b.push_back(w[8*(i%4) +: 8]);
`else
      b.push_back(w[8*(3-(i%4)) +: 8]);
`endif
    end
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    bits = 64'(sz) * 64'd8;
    for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
    n = b.size() / 4;
    for (int j = 0; j < n; j++) begin
      e.d  = {b[4*j], b[4*j+1], b[4*j+2], b[4*j+3]};
      e.bl = ((j % 16) == 15);
      e.ml = (j == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Memory: data valid in the cycle after read_en, junk otherwise
  initial begin
    bus.port_A_rddata = 32'h0;
    forever begin
      @(negedge clk);
      rd_pend   = bus.read_en;
      pend_addr = bus.port_A_addr;
      @(posedge clk);
      #1;
      bus.port_A_rddata = rd_pend ? mem[pend_addr] : $urandom;
    end
  end

  initial begin
    bus.w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        bus.w_ready = 1'b0;
        stall_cnt--;
      end else if (ready_mode) begin
        bus.w_ready = ($urandom_range(3) != 0);
      end else begin
        bus.w_ready = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", 64'({bus.w_valid, bus.read_en, bus.w_data}),
                64'({1'b1, 1'b0, prev_data}));
        if (bus.read_en) reads_seen++;
        if (bus.w_valid && bus.w_ready) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            check("extra_word", 64'(bus.w_data), 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("word%0d", words_seen),
                  64'({bus.w_data, bus.block_last, bus.msg_last}),
                  64'({e.d, e.bl, e.ml}));
          end
        end
        prev_stall = bus.w_valid && !bus.w_ready;
        prev_data  = bus.w_data;
      end
    end
  end

  task automatic run_msg(input logic [15:0] a, input logic [31:0] sz,
                         input bit glitch);
    int n;
    int rd0;
    build_expect(a, sz);
    rd0 = reads_seen;
    @(posedge clk);
    #1;
    bus.start        = 1'b1;
    bus.message_addr = a;
    bus.message_size = sz;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (glitch) begin
      repeat (3) @(posedge clk);
      #1;
      check("busy_mid", 64'(bus.busy), 64'd1);
      bus.start        = 1'b1;
      bus.message_addr = a + 16'd5;
      bus.message_size = sz + 32'd37;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_in_time", 64'(n < 4000), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("idle_after", 64'({bus.busy, bus.w_valid}), 64'd0);
    check("read_count", 64'(reads_seen - rd0), 64'((sz + 32'd3) / 32'd4));
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          base;
    logic [31:0] sz;
    logic [15:0] a;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.message_addr = 16'h0;
    bus.message_size = 32'h0;
    for (int i = 0; i < 65536; i++) mem[16'(i)] = $urandom;
    mem[16'h0100] = 32'h6162_6300;
    #12;
    check("reset_outs",
          64'({bus.w_valid, bus.read_en, bus.block_last, bus.msg_last,
               bus.busy, bus.port_A_addr, bus.w_data}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    ready_mode = 1'b0;
    run_msg(16'h0100, 32'd3, 1'b0);
    run_msg(16'($urandom), 32'd0, 1'b0);
    run_msg(16'($urandom), 32'd56, 1'b0);
    run_msg(16'($urandom), 32'd55, 1'b0);
    run_msg(16'hFFFE, 32'd13, 1'b0);

    base = words_seen;
    fork
      run_msg(16'h0100, 32'd3, 1'b0);
      begin
        n = 0;
        while (words_seen - base < 5 && n < 200) begin
          @(negedge clk);
          #1;
          n++;
        end
        stall_cnt = 5;
      end
    join

    base = words_seen;
    build_expect(16'h0100, 32'd3);
    @(posedge clk);
    #1;
    bus.start        = 1'b1;
    bus.message_addr = 16'h0100;
    bus.message_size = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (words_seen - base < 7 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_outs",
          64'({bus.w_valid, bus.read_en, bus.block_last, bus.msg_last,
               bus.busy, bus.port_A_addr, bus.w_data}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no_resume", 64'({bus.busy, bus.w_valid, bus.read_en}), 64'd0);
    run_msg(16'h0100, 32'd3, 1'b0);

    ready_mode = 1'b1;
    run_msg(16'($urandom), 32'd1, 1'b0);
    run_msg(16'($urandom), 32'd2, 1'b1);
    run_msg(16'($urandom), 32'd4, 1'b0);
    run_msg(16'($urandom), 32'd64, 1'b0);

    for (int t = 0; t < 30; t++) begin
      ready_mode = ($urandom_range(1) != 0);
      a  = 16'($urandom);
      sz = ($urandom_range(3) == 0) ? 32'($urandom_range(8))
                                    : 32'($urandom_range(200));
      run_msg(a, sz, ($urandom_range(3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
